// File: rtl/prefetch_unit_pkg.sv
// prefetch_unit_pkg -- shared core definitions for the instruction prefetch unit.
//   XLEN              : architectural register / address width
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   redirect_src_e    : encoding of the source that redirects the fetch stream
//   fetch_entry_t     : {pc, instr} pair stored in the fetch queue
//   redirect_source() : resolves simultaneous redirect requests (branch wins)
package prefetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_CSR    = 2'd2
  } redirect_src_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = 2 * XLEN;

  // Branch/jump redirects come from an older instruction than a trap/mret
  // redirect, so they take precedence when both fire together.
  function automatic redirect_src_e redirect_source(input logic branch, input logic csr);
    redirect_src_e src;
    src = REDIR_NONE;
    if (branch) begin
      src = REDIR_BRANCH;
    end else if (csr) begin
      src = REDIR_CSR;
    end
    return src;
  endfunction

endpackage

// File: rtl/prefetch_unit_fifo.sv
// fetch_fifo -- circular queue of fetched {pc, instr} entries.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empties the queue in one cycle (redirect)
//   push, push_data : write an entry at the tail
//   pop             : remove the head entry
//   head_data       : current head entry (valid while count != 0)
//   count, empty    : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty     = (cnt == '0);
    full      = (cnt == (PW+1)'(DEPTH));
    do_pop    = pop && !empty;
    // A push into a full queue is legal when the head leaves in the same edge.
    do_push   = push && (!full || do_pop);
    head_data = storage[rd_ptr];
    count     = cnt;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + (PW+1)'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit -- instruction prefetcher feeding the decode stage.
//   clk, reset                     : clock, synchronous active-high reset
//   redirect_valid / redirect_pc   : branch/jump redirect (highest priority)
//   csr_update_pc / csr_pc_update  : trap/mret redirect
//   cpu_halt                       : stop issuing new fetches
//   mem_req_valid/ready/addr       : fetch request, word address (pc >> 2)
//   mem_resp_valid / mem_resp_data : in-order responses, one per accepted request
//   out_valid / out_ready          : decode handshake
//   out_instr / out_pc / out_pc_4  : instruction, its address, address + 4
//   pc_trap                        : head entry pc is not word aligned
// Build option: define PREFETCH_BYPASS_EN to forward a response straight to
// out_* when the queue is empty and nothing is being discarded.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            csr_update_pc,
  input  logic [XLEN-1:0] csr_pc_update,
  input  logic            cpu_halt,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_4,
  output logic            pc_trap
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;

  logic [XLEN-1:0] fetch_pc;
  // inflight counts outstanding requests whose data will be kept; discard
  // counts outstanding requests abandoned by a redirect or reset.
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   resp_dec;

  redirect_src_e   redir_src;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  logic            req_fire;
  logic            resp_live;
  logic            resp_drop;
  logic            bypass_hit;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  logic [PW:0]     fifo_count;
  fetch_entry_t    resp_entry;
  fetch_entry_t    head_entry;
  fetch_entry_t    out_entry;

  always_comb begin
    redir_src = redirect_source(redirect_valid, csr_update_pc);
    redirect  = (redir_src != REDIR_NONE);
    case (redir_src)
      REDIR_BRANCH: redirect_target = redirect_pc;
      REDIR_CSR:    redirect_target = csr_pc_update;
      default:      redirect_target = fetch_pc;
    endcase
  end

  always_comb begin
    outstanding = inflight + discard;
    occupancy   = CW'(fifo_count) + outstanding;

    // Every outstanding request reserves a queue slot, discarded ones
    // included, so a kept response always finds room.
    mem_req_valid = !reset && !cpu_halt && !redirect && (occupancy < CW'(DEPTH));
    mem_req_addr  = {2'b00, fetch_pc[XLEN-1:2]};
    req_fire      = mem_req_valid && mem_req_ready;

    resp_live = mem_resp_valid && (discard == '0) && (inflight != '0);
    resp_drop = mem_resp_valid && (discard != '0);
    resp_dec  = CW'(mem_resp_valid && (outstanding != '0));

    // Kept requests are contiguous from the last redirect, so the oldest
    // one sits inflight words behind the fetch pc.
    resp_entry.pc    = fetch_pc - (XLEN'(inflight) << 2);
    resp_entry.instr = mem_resp_data;
  end

  always_comb begin
`ifdef PREFETCH_BYPASS_EN
    bypass_hit = fifo_empty && resp_live;
`else
    bypass_hit = 1'b0;
`endif
    out_entry = bypass_hit ? resp_entry : head_entry;
    out_valid = !fifo_empty || bypass_hit;
    out_instr = out_entry.instr;
    out_pc    = out_entry.pc;
    out_pc_4  = out_entry.pc + 32'd4;
    pc_trap   = (out_entry.pc[1:0] != 2'b00);

    fifo_pop  = out_ready && !fifo_empty && !redirect;
    fifo_push = resp_live && !redirect && !(bypass_hit && out_ready);
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (resp_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Reset and redirect both turn every still-outstanding request into a
  // discard; a response arriving in that same cycle retires one of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= outstanding - resp_dec;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      inflight <= '0;
      discard  <= outstanding - resp_dec;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      inflight <= inflight + CW'(req_fire) - CW'(resp_live);
      discard  <= discard - CW'(resp_drop);
    end
  end

endmodule
